poly_fifo_wr_sequencer: RTL and testbench

Write-side sequencer for the double-buffered polynomial FIFO that carries polynomials between pipeline stages. It accepts a valid/ready stream of line pairs from an upstream producer, such as the global load path or the key-switch output. It then drives the FIFO source handshake (`wr_finish`, `addrA`/`addrB`, data, per-word write selects) so that each polynomial lands in one FIFO buffer and the buffer is committed exactly once. It never starts a buffer while the FIFO reports full.

---
 rtl/poly_fifo_wr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_poly_fifo_wr_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_fifo_wr_sequencer.sv
// poly_fifo_wr_sequencer
//   Write-side sequencer for the double-buffered polynomial FIFO. It takes a
//   valid/ready stream of line pairs and drives the FIFO source handshake so
//   that each polynomial fills one buffer and commits it exactly once. It never
//   claims a new buffer while the FIFO reports full.
//
// Ports
//   i_clk, i_rstn                 clock, async active-low reset
//   i_in_valid / o_in_ready       upstream pair handshake
//   i_in_da, i_in_db              even / odd line of the pair
//   i_fifo_full                   FIFO source full flag
//   o_fifo_wr_finish              FIFO source wr_finish (high = not writing)
//   o_fifo_addr_a/_b              line write addresses (2k, 2k+1)
//   o_fifo_da/_db                 line write data
//   o_fifo_word_sel_a/_b          per-word write enables
//   o_busy                        state != IDLE
//   o_poly_done                   one-cycle pulse in the commit cycle
//   o_poly_cnt                    committed polynomials, wraps at 2^16
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | buffer not claimed; wait for in_valid with FIFO not full
// FILL  | buffer claimed; accept PAIRS beats, write each one cycle later
// DONE  | last pair written together with wr_finish; commit cycle
module poly_fifo_wr_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int PAIRS      = 2 ** (ADDR_WIDTH - 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_da,
  input  logic [DATA_WIDTH-1:0] i_in_db,
  input  logic                  i_fifo_full,
  output logic                  o_fifo_wr_finish,
  output logic [ADDR_WIDTH-1:0] o_fifo_addr_a,
  output logic [ADDR_WIDTH-1:0] o_fifo_addr_b,
  output logic [DATA_WIDTH-1:0] o_fifo_da,
  output logic [DATA_WIDTH-1:0] o_fifo_db,
  output logic [SEL_WIDTH-1:0]  o_fifo_word_sel_a,
  output logic [SEL_WIDTH-1:0]  o_fifo_word_sel_b,
  output logic                  o_busy,
  output logic                  o_poly_done,
  output logic [15:0]           o_poly_cnt
);

  // Pair index k only needs to address half the lines; the line address is
  // formed by appending the even/odd bit.
  localparam int KW = ADDR_WIDTH - 1;
  localparam logic [KW-1:0] LAST_K = KW'(PAIRS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic                  r_wr_finish;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [DATA_WIDTH-1:0] r_da;
  logic [DATA_WIDTH-1:0] r_db;
  logic [SEL_WIDTH-1:0]  r_sel_a;
  logic [SEL_WIDTH-1:0]  r_sel_b;
  logic                  r_poly_done;
  logic [15:0]           r_poly_cnt;

  logic                  w_accept;

  assign o_in_ready = (r_state == S_FILL);
  assign o_busy     = (r_state != S_IDLE);
  assign w_accept   = i_in_valid && (r_state == S_FILL);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_wr_finish <= 1'b1;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_da        <= '0;
      r_db        <= '0;
      r_sel_a     <= '0;
      r_sel_b     <= '0;
      r_poly_done <= 1'b0;
      r_poly_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sel_a     <= '0;
          r_sel_b     <= '0;
          r_poly_done <= 1'b0;
          r_wr_finish <= 1'b1;
          // Dropping wr_finish here claims the buffer one cycle before the
          // first write reaches the FIFO.
          if (i_in_valid && !i_fifo_full) begin
            r_state     <= S_FILL;
            r_wr_finish <= 1'b0;
          end
        end

        S_FILL: begin
          if (w_accept) begin
            r_addr_a <= {r_k, 1'b0};
            r_addr_b <= {r_k, 1'b1};
            r_da     <= i_in_da;
            r_db     <= i_in_db;
            r_sel_a  <= '1;
            r_sel_b  <= '1;
            if (r_k == LAST_K) begin
              // Final write and commit land in the same cycle.
              r_k         <= '0;
              r_wr_finish <= 1'b1;
              r_poly_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end else begin
            // Bubble: write enable stays active but no word is selected.
            r_sel_a <= '0;
            r_sel_b <= '0;
          end
        end

        S_DONE: begin
          r_sel_a     <= '0;
          r_sel_b     <= '0;
          r_wr_finish <= 1'b1;
          r_poly_done <= 1'b0;
          r_poly_cnt  <= r_poly_cnt + 16'd1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_wr_finish <= 1'b1;
          r_sel_a     <= '0;
          r_sel_b     <= '0;
          r_poly_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_wr_finish  = r_wr_finish;
  assign o_fifo_addr_a     = r_addr_a;
  assign o_fifo_addr_b     = r_addr_b;
  assign o_fifo_da         = r_da;
  assign o_fifo_db         = r_db;
  assign o_fifo_word_sel_a = r_sel_a;
  assign o_fifo_word_sel_b = r_sel_b;
  assign o_poly_done       = r_poly_done;
  assign o_poly_cnt        = r_poly_cnt;

endmodule

// File: tb/tb_poly_fifo_wr_sequencer.sv
module tb_poly_fifo_wr_sequencer;

  localparam int DW    = 64;
  localparam int SW    = 4;
  localparam int AW    = 3;
  localparam int PAIRS = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_da = '0;
  logic [DW-1:0] in_db = '0;
  logic          fifo_full;
  logic          wr_finish;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] f_da, f_db;
  logic [SW-1:0] sel_a, sel_b;
  logic          busy;
  logic          poly_done;
  logic [15:0]   poly_cnt;

  // Simple FIFO occupancy model: full when two committed buffers are unread.
  logic          use_model = 1'b0;
  logic          full_force = 1'b0;
  int            commit_cnt = 0;
  int            drain_cnt = 0;
  assign fifo_full = use_model ? ((commit_cnt - drain_cnt) >= 2) : full_force;

  poly_fifo_wr_sequencer #(
    .DATA_WIDTH(DW), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .PAIRS(PAIRS)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_da(in_da), .i_in_db(in_db),
    .i_fifo_full(fifo_full),
    .o_fifo_wr_finish(wr_finish),
    .o_fifo_addr_a(addr_a), .o_fifo_addr_b(addr_b),
    .o_fifo_da(f_da), .o_fifo_db(f_db),
    .o_fifo_word_sel_a(sel_a), .o_fifo_word_sel_b(sel_b),
    .o_busy(busy), .o_poly_done(poly_done), .o_poly_cnt(poly_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic          fin;
  } wr_t;

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          gaps;
  } vec_t;

  wr_t           sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_writes = 0;
  int            n_gaps = 0;
  int            exp_cnt = 0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_da = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle: advance to the falling edge and check whatever the FIFO sees.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (sel_a != '0 || sel_b != '0) begin
      n_writes++;
      chk("sel_a_ones", 64'(sel_a), 64'({SW{1'b1}}));
      chk("sel_b_ones", 64'(sel_b), 64'({SW{1'b1}}));
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("addr_a", 64'(addr_a), 64'(e.a));
        chk("addr_b", 64'(addr_b), 64'(e.b));
        chk("data_a", f_da, e.da);
        chk("data_b", f_db, e.db);
        chk("wr_finish_on_write", 64'(wr_finish), 64'(e.fin));
        chk("poly_done_on_write", 64'(poly_done), 64'(e.fin));
        last_a  = e.a;
        last_da = e.da;
      end
      if (wr_finish) commit_cnt++;
    end else if (in_ready) begin
      n_gaps++;
      chk("gap_wr_finish", 64'(wr_finish), 64'(0));
      chk("gap_addr_hold", 64'(addr_a), 64'(last_a));
      chk("gap_data_hold", f_da, last_da);
    end else if (!busy) begin
      chk("idle_wr_finish", 64'(wr_finish), 64'(1));
    end
  endtask

  // Drive one polynomial; pat[i] is the in_valid value for the i-th FILL cycle.
  task automatic drive_poly(input logic [15:0] pat, input int len, input int exp_lat, input int exp_gaps);
    int  k = 0;
    int  i = 0;
    int  c = -1;
    bit  got_done = 0;
    logic v;
    wr_t e;
    n_writes = 0;
    n_gaps = 0;
    for (int t = 0; t < 300 && !got_done; t++) begin
      tick();
      if (c >= 0) c++;
      if (poly_done) begin
        got_done = 1;
        if (exp_lat >= 0) chk("done_latency", 64'(c), 64'(exp_lat));
      end else if (k < PAIRS) begin
        if (in_ready) begin
          if (c < 0) c = 0;
          v = (i < len) ? pat[i] : 1'b1;
          i++;
        end else begin
          v = 1'b1;
        end
        in_valid = v;
        in_da = {$urandom, $urandom};
        in_db = {$urandom, $urandom};
        if (in_ready && v) begin
          e.a = AW'(2 * k);
          e.b = AW'(2 * k + 1);
          e.da = in_da;
          e.db = in_db;
          e.fin = (k == PAIRS - 1);
          sb.push_back(e);
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (!got_done) chk("poly_done_timeout", 64'(0), 64'(1));
    exp_cnt++;
    tick();
    chk("poly_cnt", 64'(poly_cnt), 64'(16'(exp_cnt)));
    chk("writes_per_poly", 64'(n_writes), 64'(PAIRS));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    if (exp_gaps >= 0) chk("gap_cycles", 64'(n_gaps), 64'(exp_gaps));
  endtask

  initial begin
    vec_t vecs[3];
    int   base;
    wr_t  e;
    vecs[0] = '{pat: 16'b1111,     len: 4, gaps: 1};
    vecs[1] = '{pat: 16'b1011001,  len: 7, gaps: 4};
    vecs[2] = '{pat: 16'b10001011, len: 8, gaps: 5};

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_wr_finish", 64'(wr_finish), 64'(1));
    chk("rst_poly_done", 64'(poly_done), 64'(0));
    rstn = 1'b1;
    tick();
    chk("rel_wr_finish", 64'(wr_finish), 64'(1));
    chk("rel_in_ready", 64'(in_ready), 64'(0));
    chk("rel_poly_cnt", 64'(poly_cnt), 64'(0));
    chk("rel_sel", 64'({sel_a, sel_b}), 64'(0));
    chk("rel_addr", 64'({addr_a, addr_b}), 64'(0));
    chk("rel_busy", 64'(busy), 64'(0));

    // Table: gap-free and bubbly valid patterns.
    foreach (vecs[n]) drive_poly(vecs[n].pat, vecs[n].len, vecs[n].len, vecs[n].gaps);

    // Full backpressure holds IDLE, then FILL starts the cycle after release.
    full_force = 1'b1;
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_busy", 64'(busy), 64'(0));
      chk("full_wr_finish", 64'(wr_finish), 64'(1));
      chk("full_sel", 64'({sel_a, sel_b}), 64'(0));
    end
    full_force = 1'b0;
    tick();
    chk("fill_after_full", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    drive_poly(16'b1111, 4, 4, 1);

    // Back-to-back with a depth-2 FIFO and a reader that drains late.
    use_model = 1'b1;
    commit_cnt = 0;
    drain_cnt = 0;
    base = exp_cnt;
    fork
      begin
        for (int p = 0; p < 3; p++) drive_poly(16'b1111, 4, -1, -1);
      end
      begin
        for (int t = 0; t < 200 && poly_cnt != 16'(base + 2); t++) @(negedge clk);
        chk("b2b_two_commits", 64'(poly_cnt), 64'(16'(base + 2)));
        repeat (10) @(negedge clk);
        chk("b2b_stall_cnt", 64'(poly_cnt), 64'(16'(base + 2)));
        chk("b2b_stall_busy", 64'(busy), 64'(0));
        chk("b2b_stall_finish", 64'(wr_finish), 64'(1));
        drain_cnt = drain_cnt + 1;
      end
    join
    chk("b2b_third_commit", 64'(poly_cnt), 64'(16'(base + 3)));
    use_model = 1'b0;

    // Reset after pair 1 abandons the polynomial.
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !in_ready; t++) tick();
    chk("midrst_fill", 64'(in_ready), 64'(1));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) tick();
      in_da = {$urandom, $urandom};
      in_db = {$urandom, $urandom};
      e.a = AW'(2 * k);
      e.b = AW'(2 * k + 1);
      e.da = in_da;
      e.db = in_db;
      e.fin = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("midrst_pair1_addr", 64'(addr_a), 64'(2));
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_wr_finish", 64'(wr_finish), 64'(1));
    chk("midrst_sel", 64'({sel_a, sel_b}), 64'(0));
    chk("midrst_addr", 64'({addr_a, addr_b}), 64'(0));
    chk("midrst_poly_cnt", 64'(poly_cnt), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    sb.delete();
    last_a = '0;
    last_da = '0;
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    drive_poly(16'b1111, 4, 4, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
